// File: rtl/fir_filter.sv
// 8-tap direct-form FIR low-pass filter with fixed symmetric coefficients.
// Produces a full-precision registered output and a registered copy of the newest sample.
module fir_filter #(
  parameter int N1 = 8,   // coefficient width
  parameter int N2 = 16,  // sample width
  parameter int N3 = 32   // output width
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic signed [N2-1:0] input_data,
  input  logic                 Enable,
  output logic signed [N3-1:0] output_data,
  output logic signed [N2-1:0] sampleT
);

  localparam int TAPS = 8;
  localparam int PW   = N1 + N2;

  localparam logic signed [N1-1:0] coef [TAPS] = '{
    N1'(-2), N1'(3), N1'(20), N1'(43), N1'(43), N1'(20), N1'(3), N1'(-2)
  };

  logic signed [N2-1:0] x    [TAPS];
  logic signed [N2-1:0] taps [TAPS];
  logic signed [N3-1:0] acc_next;

  // The output includes the sample being accepted, so tap 0 is the live input.
  always_comb begin
    taps[0] = input_data;
    for (int k = 1; k < TAPS; k++) begin
      taps[k] = x[k-1];
    end
  end

  always_comb begin
    logic signed [PW-1:0] prod;
    acc_next = '0;
    prod     = '0;
    for (int k = 0; k < TAPS; k++) begin
      prod     = taps[k] * coef[k];
      acc_next = acc_next + {{(N3-PW){prod[PW-1]}}, prod};
    end
  end

  // NOTE: the delay line is reset too, so the filter restarts from an empty history.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int k = 0; k < TAPS; k++) begin
        x[k] <= '0;
      end
      output_data <= '0;
      sampleT     <= '0;
    end else if (Enable) begin
      x[0] <= input_data;
      for (int k = 1; k < TAPS; k++) begin
        x[k] <= x[k-1];
      end
      output_data <= acc_next;
      sampleT     <= input_data;
    end
  end

endmodule

// File: tb/tb_fir_filter.sv
// Directed and random-stream bench for fir_filter: reset, impulse, step with
// enable gating, negative full scale, asynchronous reset and a convolution model.
module tb_fir_filter;

  logic               CLK = 1'b0;
  logic               RST;
  logic signed [15:0] input_data;
  logic               Enable;
  logic signed [31:0] output_data;
  logic signed [15:0] sampleT;

  int total = 0;
  int bad   = 0;

  int hc [8] = '{-2, 3, 20, 43, 43, 20, 3, -2};
  logic signed [15:0] mx [8];

  fir_filter dut (
    .CLK        (CLK),
    .RST        (RST),
    .input_data (input_data),
    .Enable     (Enable),
    .output_data(output_data),
    .sampleT    (sampleT)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic signed [31:0] got,
                       input logic signed [31:0] expv);
    total++;
    if (got !== expv) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, expv);
    end
  endtask

  task automatic cycle(input logic signed [15:0] d, input logic en);
    input_data = d;
    Enable     = en;
    @(posedge CLK);
    #1;
  endtask

  function automatic int golden(input logic signed [15:0] s);
    int acc;
    acc = hc[0] * int'(s);
    for (int k = 1; k < 8; k++) acc += hc[k] * int'(mx[k-1]);
    return acc;
  endfunction

  task automatic push(input logic signed [15:0] s);
    for (int k = 7; k > 0; k--) mx[k] = mx[k-1];
    mx[0] = s;
  endtask

  int imp_exp  [10] = '{-2, 3, 20, 43, 43, 20, 3, -2, 0, 0};
  int step_a   [4]  = '{-200, 100, 2100, 6400};
  int step_b   [6]  = '{10700, 12700, 13000, 12800, 12800, 12800};

  initial begin
    logic signed [15:0] s;
    int e;

    RST = 1'b0; Enable = 1'b0; input_data = 16'sd0;
    repeat (2) @(posedge CLK);
    #1;
    check("reset_out", output_data, 0);
    check("reset_samp", sampleT, 0);
    @(negedge CLK) RST = 1'b1;
    input_data = 16'sd99;
    @(posedge CLK); #1;
    check("post_reset_idle_out", output_data, 0);
    check("post_reset_idle_samp", sampleT, 0);

    // Impulse
    for (int i = 0; i < 10; i++) begin
      cycle((i == 0) ? 16'sd1 : 16'sd0, 1'b1);
      check($sformatf("impulse_out[%0d]", i), output_data, imp_exp[i]);
      check($sformatf("impulse_samp[%0d]", i), sampleT, (i == 0) ? 1 : 0);
    end

    // Step with a three-cycle enable gap partway through
    for (int i = 0; i < 4; i++) begin
      cycle(16'sd100, 1'b1);
      check($sformatf("step_out[%0d]", i), output_data, step_a[i]);
    end
    for (int i = 0; i < 3; i++) begin
      cycle(16'(777 + i * 1000), 1'b0);
      check($sformatf("gated_out[%0d]", i), output_data, 6400);
      check($sformatf("gated_samp[%0d]", i), sampleT, 100);
    end
    for (int i = 0; i < 6; i++) begin
      cycle(16'sd100, 1'b1);
      check($sformatf("step_resume_out[%0d]", i), output_data, step_b[i]);
    end

    // Negative full scale
    for (int i = 0; i < 10; i++) begin
      cycle(-16'sd32768, 1'b1);
      if (i >= 7) begin
        check($sformatf("negfs_out[%0d]", i), output_data, -4194304);
        check($sformatf("negfs_samp[%0d]", i), sampleT, -32768);
      end
    end

    // Asynchronous reset mid-cycle with live nonzero data
    input_data = 16'sd1234; Enable = 1'b1;
    #3;
    RST = 1'b0;
    #1;
    check("async_reset_out", output_data, 0);
    check("async_reset_samp", sampleT, 0);
    @(posedge CLK); #1;
    check("reset_held_out", output_data, 0);
    Enable = 1'b0;
    @(negedge CLK) RST = 1'b1;
    @(posedge CLK); #1;
    check("release_idle_out", output_data, 0);
    cycle(16'sd5, 1'b1);
    check("empty_line_out", output_data, -10);
    check("empty_line_samp", sampleT, 5);

    // Random stream against the convolution model
    RST = 1'b0; Enable = 1'b0;
    #1;
    @(negedge CLK) RST = 1'b1;
    for (int k = 0; k < 8; k++) mx[k] = 16'sd0;
    for (int i = 0; i < 100; i++) begin
      s = 16'($urandom);
      e = golden(s);
      push(s);
      cycle(s, 1'b1);
      check($sformatf("rand_out[%0d]", i), output_data, e);
      check($sformatf("rand_samp[%0d]", i), sampleT, 32'(s));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
